// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared registered 2:1 mux.
// Round-robin on contention, with a hold limit that forces rotation while both sides request.
module mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             select,
  output logic [WIDTH-1:0] s,
  output logic             valid
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] CntMax = 4'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             gnt_a_q, gnt_b_q, select_q, valid_q;
  logic [WIDTH-1:0] s_q;

  // Next owner is decided purely from sampled requests, the pointer and the hold count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !ptr_q)) state_d = OWN_A;
        else if (req_b)                  state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                       state_d = req_b ? OWN_B : IDLE;
        else if (req_b && cnt_q == CntMax) state_d = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                       state_d = req_a ? OWN_A : IDLE;
        else if (req_a && cnt_q == CntMax) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_d == OWN_A && state_q != OWN_A) ptr_d = 1'b1;
    if (state_d == OWN_B && state_q != OWN_B) ptr_d = 1'b0;

    // Count restarts on any ownership change and saturates so a sole requester never wraps.
    cnt_d = cnt_q;
    if (state_d != state_q || state_q == IDLE) cnt_d = 4'd0;
    else if (cnt_q != CntMax)                  cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= 4'd0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      select_q <= 1'b0;
      s_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
      select_q <= (state_d == OWN_B);
      // Data follows the owner of the cycle that just ended, so valid lags grant by one.
      unique case (state_q)
        OWN_A: begin
          s_q     <= a;
          valid_q <= 1'b1;
        end
        OWN_B: begin
          s_q     <= b;
          valid_q <= 1'b1;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign select = select_q;
  assign s      = s_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against an ownership/run-length model.
module tb_mux_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             reset;
  logic             req_a, req_b;
  logic [WIDTH-1:0] a, b;
  logic             gnt_a, gnt_b, select, valid;
  logic [WIDTH-1:0] s;

  int total = 0;
  int bad   = 0;
  bit checkEn = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; held = cycles the current owner has had the grant.
  int             mOwner = 0;
  int             mHeld  = 0;
  int             mPtr   = 0;
  logic [WIDTH-1:0] mS   = '0;
  logic           mValid = 0;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .a      (a),
    .b      (b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .select (select),
    .s      (s),
    .valid  (valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    int nextOwner, mine, other, otherId;
    if (reset) begin
      mOwner = 0; mHeld = 0; mPtr = 0; mS = '0; mValid = 0;
    end else begin
      if (mOwner == 1) begin mS = a; mValid = 1; end
      else if (mOwner == 2) begin mS = b; mValid = 1; end
      else mValid = 0;

      nextOwner = mOwner;
      if (mOwner == 0) begin
        if (req_a && req_b) nextOwner = (mPtr != 0) ? 2 : 1;
        else if (req_a)     nextOwner = 1;
        else if (req_b)     nextOwner = 2;
      end else begin
        mine    = (mOwner == 1) ? int'(req_a) : int'(req_b);
        other   = (mOwner == 1) ? int'(req_b) : int'(req_a);
        otherId = 3 - mOwner;
        if (mine == 0)                          nextOwner = (other != 0) ? otherId : 0;
        else if (other != 0 && mHeld >= MAX_HOLD) nextOwner = otherId;
      end

      if (nextOwner != mOwner) mHeld = (nextOwner == 0) ? 0 : 1;
      else if (mOwner != 0 && mHeld < 100000) mHeld++;
      if (nextOwner == 1 && mOwner != 1) mPtr = 1;
      if (nextOwner == 2 && mOwner != 2) mPtr = 0;
      mOwner = nextOwner;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic ra, input logic rb,
                               input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    req_a = ra; req_b = rb; a = av; b = bv;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    reset = 0;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_gnt_a",  32'(gnt_a),  32'(mOwner == 1));
      checkOutput("model_gnt_b",  32'(gnt_b),  32'(mOwner == 2));
      checkOutput("model_select", 32'(select), 32'(mOwner == 2));
      checkOutput("model_valid",  32'(valid),  32'(mValid));
      checkOutput("model_s",      32'(s),      32'(mS));
      checkOutput("exclusive",    32'(gnt_a & gnt_b), 32'(0));
    end
  end

  initial begin
    reset = 1; req_a = 0; req_b = 0; a = '0; b = '0;
    @(negedge clk);
    checkEn = 1;
    doReset();
    checkOutput("reset_gnt_a", 32'(gnt_a), 0);
    checkOutput("reset_s",     32'(s),     0);
    checkOutput("reset_valid", 32'(valid), 0);

    // Sole requester A holds indefinitely.
    applyStimulus(1, 0, 4'h5, 4'h0);
    checkOutput("solo_gnt_e1",   32'(gnt_a), 1);
    checkOutput("solo_valid_e1", 32'(valid), 0);
    applyStimulus(1, 0, 4'h5, 4'h0);
    checkOutput("solo_s_e2",     32'(s),     5);
    checkOutput("solo_valid_e2", 32'(valid), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'h5, 4'h0);
    checkOutput("solo_gnt_e6", 32'(gnt_a),  1);
    checkOutput("solo_sel_e6", 32'(select), 0);

    // Continuous contention rotates every MAX_HOLD cycles.
    doReset();
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1, 1, 4'(e), 4'(e + 8));
      if (e == 4) checkOutput("rot_gnt_a_e4", 32'(gnt_a), 1);
      if (e == 5) checkOutput("rot_sel_e5",   32'(select), 1);
      if (e == 8) checkOutput("rot_gnt_b_e8", 32'(gnt_b), 1);
      if (e == 9) checkOutput("rot_sel_e9",   32'(select), 0);
    end

    // Direct handover when A drops while B waits.
    doReset();
    applyStimulus(1, 0, 4'h1, 4'h0);
    applyStimulus(1, 0, 4'h1, 4'h0);
    applyStimulus(0, 1, 4'h1, 4'hA);
    checkOutput("hand_gnt_b", 32'(gnt_b),  1);
    checkOutput("hand_sel",   32'(select), 1);
    checkOutput("hand_gnt_a", 32'(gnt_a),  0);
    applyStimulus(0, 1, 4'h1, 4'hA);
    checkOutput("hand_s", 32'(s), 4'hA);

    // Gap then contention: pointer favours B after A's turn.
    doReset();
    applyStimulus(1, 0, 4'h3, 4'h0);
    applyStimulus(1, 0, 4'h3, 4'h0);
    applyStimulus(0, 0, 4'h3, 4'h0);
    checkOutput("gap_idle", 32'(gnt_a | gnt_b), 0);
    applyStimulus(1, 1, 4'h3, 4'h6);
    checkOutput("gap_gnt_b", 32'(gnt_b), 1);
    checkOutput("gap_valid", 32'(valid), 0);

    // Reset mid-grant in OWN_B, then first decision uses ptr=0.
    doReset();
    for (int e = 1; e <= 7; e++) applyStimulus(1, 1, 4'h7, 4'h9);
    reset = 1;
    applyStimulus(1, 1, 4'h7, 4'h9);
    checkOutput("rst_mid_outs", 32'({gnt_a, gnt_b, select, valid, s}), 0);
    reset = 0;
    applyStimulus(1, 1, 4'h7, 4'h9);
    checkOutput("rst_mid_gnt_a", 32'(gnt_a), 1);

    // Random traffic, biased toward contention, with rare resets.
    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 7),
                    WIDTH'($urandom), WIDTH'($urandom));
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each requester data word and of the shared output.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles while the other side is requesting; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-005 req_a  input  1  requester A wants the shared path.
REQ-006 req_b  input  1  requester B wants the shared path.
REQ-007 a  input  WIDTH  requester A data.
REQ-008 b  input  WIDTH  requester B data.
REQ-009 gnt_a  output  1  A owns the path this cycle (registered).
REQ-010 gnt_b  output  1  B owns the path this cycle (registered).
REQ-011 select  output  1  shared 2:1 mux select; 0 = a, 1 = b (registered).
REQ-012 s  output  WIDTH  registered shared-path output word.
REQ-013 valid  output  1  s holds a word captured from the owner (registered).

Function
REQ-014 FSM states: IDLE, OWN_A, OWN_B; gnt_a = (state==OWN_A), gnt_b = (state==OWN_B); gnt_a and gnt_b never both 1.
REQ-015 select = 1 only in OWN_B; 0 in IDLE and OWN_A.
REQ-016 One-bit priority pointer ptr (0 = A preferred, 1 = B preferred); on every entry into OWN_A ptr <= 1, on every entry into OWN_B ptr <= 0.
REQ-017 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> OWN_A if ptr==0 else OWN_B; neither -> IDLE.
REQ-018 Grant latency: request sampled at edge N gives grant visible after edge N (one cycle from request assertion seen in IDLE).
REQ-019 Hold counter cnt, 4 bits, cleared to 0 on every grant-state entry (including A->B and B->A direct handovers), incremented each edge the state is unchanged, saturating at MAX_HOLD-1.
REQ-020 OWN_A: !req_a & req_b -> OWN_B; !req_a & !req_b -> IDLE; req_a & req_b & cnt==MAX_HOLD-1 -> OWN_B (forced rotation); otherwise stay.
REQ-021 OWN_B: symmetric to REQ-020 with A/B swapped.
REQ-022 Sole requester never preempted: with other req low, owner keeps grant indefinitely; cnt saturates, no wrap.
REQ-023 Data path: at each edge where current state is OWN_A, s <= a and valid <= 1; OWN_B, s <= b and valid <= 1; IDLE, valid <= 0 and s holds last value.
REQ-024 Data latency: word presented at edge N with grant active appears on s after edge N; valid tracks grant delayed one cycle.
REQ-025 Handover A->B: no idle cycle inserted; select switches 0->1 on the same edge gnt_a falls and gnt_b rises.
REQ-026 Requests dropping and rising on the same edge in an owner state: evaluated per REQ-020/021 from sampled values only; no combinational path from req_* to gnt_*.

Reset
REQ-027 When reset=1 at an edge: state <= IDLE, ptr <= 0, cnt <= 0, gnt_a <= 0, gnt_b <= 0, select <= 0, s <= 0, valid <= 0.
REQ-028 Reset has priority over all transitions, including mid-grant and during forced rotation; first post-reset decision uses ptr=0.
REQ-029 Outputs are undefined only before the first reset edge; benches shall apply reset for at least one edge.

Verification
REQ-030 Reset, then req_a=1, a=4'h5, req_b=0 for 6 edges -> gnt_a=1 after edge 1 and held through edge 6; s=5, valid=1 from edge 2; select=0 throughout.
REQ-031 Reset, then req_a=req_b=1 continuously, MAX_HOLD=4 -> OWN_A edges 1-4, OWN_B edges 5-8, OWN_A 9-12; gnt never overlaps; select toggles on edges 5, 9.
REQ-032 In OWN_A with cnt=1, drop req_a, req_b=1, b=4'hA -> gnt_b=1 after next edge, select=1, s=A one edge later, no IDLE cycle.
REQ-033 Alternating single requests: A for 2 cycles, both low 1 cycle, then both high -> IDLE for one cycle, valid=0 one edge later, then grant goes to B (ptr=1).
REQ-034 Assert reset at cnt=2 in OWN_B with both requesting -> after that edge all outputs 0, state IDLE; release reset with both requesting -> gnt_a=1 after next edge.
REQ-035 Random req_a/req_b/a/b for 1000 cycles vs. reference model -> gnt_a&gnt_b never 1, no owner exceeds MAX_HOLD cycles while other requests, s/valid match REQ-023.
